// File: rtl/pong_pkg.sv
// Shared match-level constants for the pong datapath: FSM encoding, winner
// codes and default sizing, also imported by the renderer overlays.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } match_state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int SCORE_W_DEFAULT   = 4;
  localparam int WIN_SCORE_DEFAULT = 9;
  localparam int SERVE_CNT_W       = 26;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for a slow-domain level, followed by a one-cycle
// pulse on each synchronised rising edge.
module edge_sync (
  input  logic clk_out,
  input  logic reset,
  input  logic d_i,
  output logic evt_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Sync chain keeps running regardless of enable so no stale edge is left behind
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign evt_o = sync2_q & ~prev_q;

endmodule

// File: rtl/match_ctrl.sv
// Match controller: conditions point pulses and runs the serve/play/over
// state machine, driving registered scores, ball controls and result flags.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEFAULT,
  parameter int SERVE_CYCLES = 25_000_000,
  parameter int SCORE_W      = SCORE_W_DEFAULT
) (
  input  logic               clk_out,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [1:0]         state
);

  localparam logic [SERVE_CNT_W-1:0] SERVE_LAST = SERVE_CNT_W'(SERVE_CYCLES - 1);
  localparam logic [SERVE_CNT_W-1:0] TIMER_ONE  = SERVE_CNT_W'(1);
  localparam logic [SCORE_W-1:0]     WIN_LAST   = SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W-1:0]     SCORE_ONE  = SCORE_W'(1);

  logic p1_evt;
  logic p2_evt;

  match_state_e             state_q;
  logic [SERVE_CNT_W-1:0]   timer_q;
  logic [SCORE_W-1:0]       p1_score_q;
  logic [SCORE_W-1:0]       p2_score_q;
  logic                     ball_run_q;
  logic                     ball_reset_q;
  logic                     game_over_q;
  logic [1:0]               winner_q;

  edge_sync u_sync_p1 (
    .clk_out (clk_out),
    .reset   (reset),
    .d_i     (p1_point),
    .evt_o   (p1_evt)
  );

  edge_sync u_sync_p2 (
    .clk_out (clk_out),
    .reset   (reset),
    .d_i     (p2_point),
    .evt_o   (p2_evt)
  );

  // Match FSM with all outputs registered alongside the state transitions
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
      winner_q     <= WINNER_NONE;
    end else if (!enable) begin
      // Frozen: events seen now are simply dropped
      ball_run_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q      <= ST_SERVE;
            timer_q      <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            winner_q     <= WINNER_NONE;
          end
        end
        ST_SERVE: begin
          if (timer_q == SERVE_LAST) begin
            state_q      <= ST_PLAY;
            timer_q      <= '0;
            ball_run_q   <= 1'b1;
            ball_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        ST_PLAY: begin
          ball_run_q <= 1'b1;
          // P1 has priority on a same-cycle tie; the P2 event is lost
          if (p1_evt) begin
            p1_score_q   <= p1_score_q + SCORE_ONE;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            if (p1_score_q == WIN_LAST) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= WINNER_P1;
            end else begin
              state_q <= ST_SERVE;
            end
          end else if (p2_evt) begin
            p2_score_q   <= p2_score_q + SCORE_ONE;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            if (p2_score_q == WIN_LAST) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= WINNER_P2;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ball_run_q   <= 1'b0;
          ball_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule
